// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file with retired-instruction counter.
// Define GRF_BYPASS_EN to make same-cycle reads of the register being written return W_wd.
module wb_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_instr,
  input  logic [31:0] W_pc,
  input  logic [31:0] W_DM_RD,
  input  logic [4:0]  W_GRF_WA,
  input  logic [31:0] W_ALU_result,
  input  logic [31:0] W_MDU_result,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic [31:0] W_wd,
  output logic        W_we,
  output logic [31:0] retire_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_load;
  logic        is_link;
  logic        is_mfhilo;
  logic [31:0] gpr [1:31];

  assign op    = W_instr[31:26];
  assign funct = W_instr[5:0];

  always_comb begin
    is_load   = (op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
                (op == OP_LHU) || (op == OP_LBU);
    is_link   = (op == OP_JAL) || ((op == OP_SPECIAL) && (funct == FN_JALR));
    is_mfhilo = (op == OP_SPECIAL) && ((funct == FN_MFHI) || (funct == FN_MFLO));
    W_wd      = W_ALU_result;
    if (is_load)
      W_wd = W_DM_RD;
    else if (is_link)
      W_wd = W_pc + 32'd8;
    else if (is_mfhilo)
      W_wd = W_MDU_result;
  end

  assign W_we = (W_GRF_WA != 5'd0);

  // $0 has no storage; the write enable already excludes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++)
        gpr[i] <= 32'h0;
    end else if (W_we) begin
      gpr[W_GRF_WA] <= W_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      retire_cnt <= 32'h0;
    else if (W_instr != 32'h0)
      retire_cnt <= retire_cnt + 32'd1;
  end

  always_comb begin
    D_rs_data = 32'h0;
    D_rt_data = 32'h0;
`ifdef GRF_BYPASS_EN
    if (D_rs_addr != 5'd0)
      D_rs_data = (W_we && (D_rs_addr == W_GRF_WA)) ? W_wd : gpr[D_rs_addr];
    if (D_rt_addr != 5'd0)
      D_rt_data = (W_we && (D_rt_addr == W_GRF_WA)) ? W_wd : gpr[D_rt_addr];
`else
    if (D_rs_addr != 5'd0)
      D_rs_data = gpr[D_rs_addr];
    if (D_rt_addr != 5'd0)
      D_rt_data = gpr[D_rt_addr];
`endif
  end

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed vector table, corner sequences and random traffic
// against an array-based reference model (honours GRF_BYPASS_EN when defined).
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_instr, W_pc, W_DM_RD, W_ALU_result, W_MDU_result;
  logic [4:0]  W_GRF_WA, D_rs_addr, D_rt_addr;
  logic [31:0] D_rs_data, D_rt_data, W_wd, retire_cnt;
  logic        W_we;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] dm;
    logic [31:0] alu;
    logic [31:0] mdu;
    logic [4:0]  wa;
    logic [31:0] exp_wd;
    logic        exp_we;
  } vec_t;

  vec_t vecs [12];

  wb_grf dut (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_pc(W_pc), .W_DM_RD(W_DM_RD),
    .W_GRF_WA(W_GRF_WA), .W_ALU_result(W_ALU_result), .W_MDU_result(W_MDU_result),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_rs_data(D_rs_data),
    .D_rt_data(D_rt_data), .W_wd(W_wd), .W_we(W_we), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Write-back source chosen from the instruction's class, not from any RTL signal.
  function automatic logic [31:0] ref_wd(input logic [31:0] instr, pc, dm, alu, mdu);
    int op = int'(instr[31:26]);
    int fn = int'(instr[5:0]);
    if (op inside {35, 33, 32, 37, 36}) return dm;
    if (op == 3 || (op == 0 && fn == 9)) return pc + 32'd8;
    if (op == 0 && (fn == 16 || fn == 18)) return mdu;
    return alu;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] addr);
    if (addr == 0) return 32'h0;
`ifdef GRF_BYPASS_EN
    if (addr == W_GRF_WA)
      return ref_wd(W_instr, W_pc, W_DM_RD, W_ALU_result, W_MDU_result);
`endif
    return m_regs[addr];
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, pc, dm, alu, mdu,
                               input logic [4:0] wa, rs, rt);
    W_instr = instr; W_pc = pc; W_DM_RD = dm; W_ALU_result = alu; W_MDU_result = mdu;
    W_GRF_WA = wa; D_rs_addr = rs; D_rt_addr = rt;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance the model exactly as the edge should, then clock the DUT.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 32'h0;
    end else begin
      if (W_GRF_WA != 0)
        m_regs[W_GRF_WA] = ref_wd(W_instr, W_pc, W_DM_RD, W_ALU_result, W_MDU_result);
      if (W_instr != 0) m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{"addu",      32'h00854021, 32'h0,        32'h0,        32'h1234,     32'h0,    5'd8,  32'h1234,     1'b1};
    vecs[1]  = '{"lw",        32'h8C090000, 32'h0,        32'hDEADBEEF, 32'h5,        32'h0,    5'd9,  32'hDEADBEEF, 1'b1};
    vecs[2]  = '{"jal",       32'h0C000000, 32'h3000,     32'h0,        32'h0,        32'h0,    5'd31, 32'h3008,     1'b1};
    vecs[3]  = '{"mflo",      32'h00001812, 32'h0,        32'h0,        32'h0,        32'hCAFE, 5'd3,  32'hCAFE,     1'b1};
    vecs[4]  = '{"wa0",       32'h00854021, 32'h0,        32'h0,        32'hFFFF,     32'h0,    5'd0,  32'hFFFF,     1'b0};
    vecs[5]  = '{"lb",        32'h800A0000, 32'h0,        32'hFFFFFF80, 32'h7,        32'h1,    5'd10, 32'hFFFFFF80, 1'b1};
    vecs[6]  = '{"lhu",       32'h940B0000, 32'h0,        32'h0000BEEF, 32'h7,        32'h1,    5'd11, 32'h0000BEEF, 1'b1};
    vecs[7]  = '{"lh",        32'h840C0000, 32'h0,        32'hFFFF8000, 32'h7,        32'h1,    5'd12, 32'hFFFF8000, 1'b1};
    vecs[8]  = '{"lbu",       32'h900D0000, 32'h0,        32'h000000AB, 32'h7,        32'h1,    5'd13, 32'h000000AB, 1'b1};
    vecs[9]  = '{"jalr_wrap", 32'h0000F809, 32'hFFFFFFFC, 32'h1,        32'h2,        32'h3,    5'd14, 32'h00000004, 1'b1};
    vecs[10] = '{"mfhi",      32'h00007810, 32'h0,        32'h1,        32'h2,        32'h5A5A, 5'd15, 32'h00005A5A, 1'b1};
    vecs[11] = '{"mthi_alu",  32'h02000011, 32'h100,      32'h1,        32'h77,       32'h3,    5'd16, 32'h00000077, 1'b1};

    reset = 1'b1;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
      checkOutput($sformatf("reset_rs%0d", i), D_rs_data, 32'h0);
      checkOutput($sformatf("reset_rt%0d", 31 - i), D_rt_data, 32'h0);
    end
    checkOutput("reset_cnt", retire_cnt, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].dm, vecs[i].alu, vecs[i].mdu,
                    vecs[i].wa, vecs[i].wa, 5'd0);
      checkOutput({vecs[i].name, "_wd"}, W_wd, vecs[i].exp_wd);
      checkOutput({vecs[i].name, "_we"}, {31'h0, W_we}, {31'h0, vecs[i].exp_we});
      checkOutput({vecs[i].name, "_same_cycle"}, D_rs_data, ref_read(vecs[i].wa));
      tick();
      applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, vecs[i].wa);
      checkOutput({vecs[i].name, "_stored"}, D_rt_data,
                  vecs[i].exp_we ? vecs[i].exp_wd : 32'h0);
      checkOutput({vecs[i].name, "_cnt"}, retire_cnt, 32'(i + 1));
    end

    // Same-cycle read of a register being overwritten.
    applyStimulus(32'h00854021, 32'h0, 32'h0, 32'h11, 32'h0, 5'd5, 5'd0, 5'd0);
    tick();
    applyStimulus(32'h00854021, 32'h0, 32'h0, 32'hAA, 32'h0, 5'd5, 5'd5, 5'd5);
`ifdef GRF_BYPASS_EN
    checkOutput("bypass_rs", D_rs_data, 32'hAA);
    checkOutput("bypass_rt", D_rt_data, 32'hAA);
`else
    checkOutput("nobypass_rs", D_rs_data, 32'h11);
    checkOutput("nobypass_rt", D_rt_data, 32'h11);
`endif
    tick();
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    checkOutput("reg5_after", D_rs_data, 32'hAA);

    // Reset during a write: commit and retire both dropped.
    reset = 1'b1;
    applyStimulus(32'h00854021, 32'h0, 32'h0, 32'h77, 32'h0, 5'd7, 5'd0, 5'd0);
    tick();
    reset = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5);
    checkOutput("midreset_reg7", D_rs_data, 32'h0);
    checkOutput("midreset_reg5", D_rt_data, 32'h0);
    checkOutput("midreset_cnt", retire_cnt, 32'h0);

    // Bubbles do not retire.
    for (int i = 0; i < 3; i++) tick();
    checkOutput("bubble_cnt", retire_cnt, 32'h0);

    // Writes resume on the first edge after reset.
    applyStimulus(32'h00854021, 32'h0, 32'h0, 32'h99, 32'h0, 5'd7, 5'd0, 5'd0);
    tick();
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    checkOutput("resume_reg7", D_rs_data, 32'h99);
    checkOutput("resume_cnt", retire_cnt, 32'h1);

    for (int n = 0; n < 400; n++) begin
      logic [5:0]  ops [8];
      logic [5:0]  fns [6];
      logic [31:0] instr;
      ops = '{6'b000000, 6'b000011, 6'b100011, 6'b100001, 6'b100000,
              6'b100101, 6'b100100, 6'b001001};
      fns = '{6'b001001, 6'b010000, 6'b010010, 6'b100001, 6'b010001, 6'b000000};
      instr = $urandom;
      instr[31:26] = ops[$urandom_range(7)];
      instr[5:0]   = fns[$urandom_range(5)];
      if ($urandom_range(7) == 0) instr = 32'h0;
      applyStimulus(instr, $urandom, $urandom, $urandom, $urandom,
                    5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
      checkOutput("rand_wd", W_wd, ref_wd(W_instr, W_pc, W_DM_RD, W_ALU_result, W_MDU_result));
      checkOutput("rand_we", {31'h0, W_we}, {31'h0, W_GRF_WA != 5'd0});
      checkOutput("rand_rs", D_rs_data, ref_read(D_rs_addr));
      checkOutput("rand_rt", D_rt_data, ref_read(D_rt_addr));
      tick();
      checkOutput("rand_cnt", retire_cnt, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back stage and general register file for the P6 five-stage MIPS core. Consumes the W-stage pipeline register outputs, selects the write-back value (ALU, data memory, MDU, or link address), commits it to a 32×32 register file, and serves the D-stage operand reads. Also exports the W-stage write data and enable for the forwarding network, and keeps a retired-instruction counter.

## Interface
- No parameters. Register count (32) and data width (32) are fixed.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- W_instr  in  32  instruction in W stage; 32'h0 = bubble/nop
- W_pc  in  32  PC of W_instr
- W_DM_RD  in  32  load data, already extended by M stage
- W_GRF_WA  in  5  destination register; 0 = no write
- W_ALU_result  in  32  ALU result
- W_MDU_result  in  32  HI/LO read value (mfhi/mflo)
- D_rs_addr  in  5  read port 1 address
- D_rt_addr  in  5  read port 2 address
- D_rs_data  out  32  read port 1 data
- D_rt_data  out  32  read port 2 data
- W_wd  out  32  selected write-back data, for forwarding
- W_we  out  1  write enable, for forwarding
- retire_cnt  out  32  count of non-bubble instructions retired

## Operation
- Write-data source, decoded from W_instr (op = [31:26], funct = [5:0]):
  - op ∈ {100011 lw, 100001 lh, 100000 lb, 100101 lhu, 100100 lbu} → W_DM_RD
  - op = 000011 (jal), or op = 000000 with funct = 001001 (jalr) → W_pc + 8, mod 2^32
  - op = 000000 with funct ∈ {010000 mfhi, 010010 mflo} → W_MDU_result
  - all other instructions → W_ALU_result
- W_wd is combinational from the decode and the data inputs. It is valid even when W_we = 0.
- W_we = (W_GRF_WA != 0). Register $0 is never written and always reads 32'h0.
- Commit: on a rising edge with reset = 0 and W_we = 1, reg[W_GRF_WA] <= W_wd.
- Reads are combinational:
  - address 0 → 32'h0
  - otherwise → stored value, subject to the bypass rule in Configuration
- Retire counter: on a rising edge with reset = 0 and W_instr != 0, retire_cnt <= retire_cnt + 1. Wraps from 32'hFFFFFFFF to 0.
- The block has no back-pressure and no handshake. Every cycle's W-stage contents are consumed.

## Timing
- Reset: on a rising edge with reset = 1:
  - all 31 writable registers cleared to 32'h0
  - retire_cnt cleared to 0
  - the write presented in that cycle is discarded
- Outputs after reset:
  - D_rs_data = D_rt_data = 0 (unless bypassing)
  - W_wd and W_we follow the inputs combinationally
  - retire_cnt = 0
- Write latency: the value is visible in stored-read form from the cycle after the commit edge.
- Simultaneous read and write of the same nonzero address: behaviour depends on GRF_BYPASS_EN.
- Both read ports may address the same register. Both ports return identical data.
- Reset asserted mid-stream: the cycle's commit and its retire increment are both suppressed. Writes resume on the first edge with reset = 0.

## Configuration
- GRF_BYPASS_EN defined:
  - When D_rs_addr (or D_rt_addr) == W_GRF_WA != 0, the read port returns W_wd in the same cycle (write-through).
  - The core's hazard unit then needs no W→D forwarding path.
- GRF_BYPASS_EN undefined:
  - Read ports return only stored contents. Same-cycle reads see the old value.
  - The hazard unit must forward W_wd to D itself.
- Commit, decode and counter behaviour are identical in both builds.

## Test plan
- Reset, then read all 32 addresses → all 0; retire_cnt = 0.
- W_instr = addu, W_GRF_WA = 8, W_ALU_result = 32'h1234 → W_we = 1, W_wd = 32'h1234; next cycle read rt = 8 → 32'h1234; retire_cnt = 1.
- W_instr = lw (op 100011), W_DM_RD = 32'hDEADBEEF, W_ALU_result = 32'h5, WA = 9 → reg9 = 32'hDEADBEEF. jal with W_pc = 32'h3000, WA = 31 → reg31 = 32'h3008.
- mflo, W_MDU_result = 32'hCAFE, WA = 3 → reg3 = 32'hCAFE. WA = 0 with W_ALU_result = 32'hFFFF → W_we = 0 and $0 reads 0, but retire_cnt still increments.
- Same-cycle write reg5 = 32'hAA and read rs = 5, with reg5 previously 32'h11 → 32'hAA with GRF_BYPASS_EN, 32'h11 without.
- Reset asserted during a write of reg7 = 32'h77 → reg7 = 0 and retire_cnt = 0 afterward. 32'h0 instructions (bubbles) leave retire_cnt unchanged.
